// File: rtl/fusion_sequencer_if.sv
// Bundle of sensor capture, fusion-lane and consumer signals around fusion_sequencer.
// master: the sequencer itself. slave: the filters, lane and consumer around it.
interface fusion_sequencer_if #(
  parameter int unsigned N = 6,
  parameter int unsigned W = 16
);
  logic             s1_valid;
  logic             s1_ready;
  logic [N*W-1:0]   s1_x;
  logic [N*W-1:0]   s1_p;
  logic             s2_valid;
  logic             s2_ready;
  logic [N*W-1:0]   s2_x;
  logic [N*W-1:0]   s2_p;
  logic             lane_valid;
  logic [W-1:0]     lane_p1;
  logic [W-1:0]     lane_p2;
  logic [W-1:0]     lane_x1;
  logic [W-1:0]     lane_x2;
  logic             lane_rvalid;
  logic [W-1:0]     lane_xf;
  logic [2*W-1:0]   lane_pf;
  logic             out_valid;
  logic             out_ready;
  logic [N*W-1:0]   out_x;
  logic [2*N*W-1:0] out_p;
  logic [1:0]       out_src;
  logic             err_unexp;

  modport master (
    input  s1_valid, s1_x, s1_p, s2_valid, s2_x, s2_p,
    input  lane_rvalid, lane_xf, lane_pf, out_ready,
    output s1_ready, s2_ready, lane_valid, lane_p1, lane_p2, lane_x1, lane_x2,
    output out_valid, out_x, out_p, out_src, err_unexp
  );

  modport slave (
    output s1_valid, s1_x, s1_p, s2_valid, s2_x, s2_p,
    output lane_rvalid, lane_xf, lane_pf, out_ready,
    input  s1_ready, s2_ready, lane_valid, lane_p1, lane_p2, lane_x1, lane_x2,
    input  out_valid, out_x, out_p, out_src, err_unexp
  );
endinterface

// File: rtl/fusion_sequencer.sv
// Captures one vector per sensor, streams N diagonal elements through a shared pipelined
// fusion lane, gathers in-order results and presents the fused vector. Falls back to
// single-sensor pass-through when the second sensor goes stale.
module fusion_sequencer #(
  parameter int unsigned N         = 6,
  parameter int unsigned W         = 16,
  parameter int unsigned STALE_CYC = 1000
) (
  input logic               clk,
  input logic               rst_n,
  fusion_sequencer_if.master bus_io
);
  localparam int unsigned     CntW     = $clog2(N + 1);
  localparam int unsigned     StW      = (STALE_CYC > 2) ? $clog2(STALE_CYC) : 1;
  localparam logic [CntW-1:0] NCnt     = CntW'(N);
  localparam logic [StW-1:0]  StaleMax = StW'(STALE_CYC - 1);

  typedef enum logic [1:0] {StCollect, StIssue, StDrain, StOutput} state_e;

  state_e             state_q;
  logic               slot1_q, slot2_q;
  logic [N*W-1:0]     x1_q, p1_q, x2_q, p2_q;
  logic [StW-1:0]     stale_q;
  logic [CntW-1:0]    issue_cnt_q, ret_cnt_q;
  logic [N-1:0]       zmask_q;
  logic               s1_ready_q, s2_ready_q;
  logic               lane_valid_q;
  logic [W-1:0]       lane_p1_q, lane_p2_q, lane_x1_q, lane_x2_q;
  logic               out_valid_q;
  logic [N*W-1:0]     out_x_q;
  logic [2*N*W-1:0]   out_p_q;
  logic [1:0]         out_src_q;
  logic               err_q;

  logic               s1_fire, s2_fire, slot1_nxt, slot2_nxt;
  logic               res_take;
  logic [CntW-1:0]    iss_idx, ret_idx, ret_cnt_nxt;
  logic               iss_zero;
  logic signed [W:0]  sum_p, sum_x;
  logic [W-1:0]       res_x;
  logic [2*W-1:0]     res_p;
  logic [N*W-1:0]     pt_x;
  logic [2*N*W-1:0]   pt_p;

  // Handshakes, element selection, zero-sum detection and result override.
  always_comb begin
    s1_fire     = bus_io.s1_valid & s1_ready_q;
    s2_fire     = bus_io.s2_valid & s2_ready_q;
    slot1_nxt   = slot1_q | s1_fire;
    slot2_nxt   = slot2_q | s2_fire;
    iss_idx     = (issue_cnt_q < NCnt) ? issue_cnt_q : '0;
    ret_idx     = (ret_cnt_q < NCnt) ? ret_cnt_q : '0;
    // A result is only legal while a previously issued element is still outstanding.
    res_take    = bus_io.lane_rvalid && ((state_q == StIssue) || (state_q == StDrain)) &&
                  (ret_cnt_q < issue_cnt_q);
    ret_cnt_nxt = ret_cnt_q + CntW'(res_take);
    sum_p       = {p1_q[W*iss_idx+W-1], p1_q[W*iss_idx +: W]} +
                  {p2_q[W*iss_idx+W-1], p2_q[W*iss_idx +: W]};
    iss_zero    = (sum_p == '0);
    // Zero covariance sum would divide by zero in the lane: use the plain mean instead.
    sum_x       = {x1_q[W*ret_idx+W-1], x1_q[W*ret_idx +: W]} +
                  {x2_q[W*ret_idx+W-1], x2_q[W*ret_idx +: W]};
    res_x       = zmask_q[ret_idx] ? sum_x[W:1] : bus_io.lane_xf;
    res_p       = zmask_q[ret_idx] ? '0 : bus_io.lane_pf;
    pt_x        = slot1_q ? x1_q : x2_q;
    pt_p        = '0;
    for (int i = 0; i < N; i++) begin
      pt_p[2*W*i +: 2*W] = slot1_q ? {{W{p1_q[W*i+W-1]}}, p1_q[W*i +: W]}
                                   : {{W{p2_q[W*i+W-1]}}, p2_q[W*i +: W]};
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StCollect;
      slot1_q      <= 1'b0;
      slot2_q      <= 1'b0;
      x1_q         <= '0;
      p1_q         <= '0;
      x2_q         <= '0;
      p2_q         <= '0;
      stale_q      <= '0;
      issue_cnt_q  <= '0;
      ret_cnt_q    <= '0;
      zmask_q      <= '0;
      s1_ready_q   <= 1'b0;
      s2_ready_q   <= 1'b0;
      lane_valid_q <= 1'b0;
      lane_p1_q    <= '0;
      lane_p2_q    <= '0;
      lane_x1_q    <= '0;
      lane_x2_q    <= '0;
      out_valid_q  <= 1'b0;
      out_x_q      <= '0;
      out_p_q      <= '0;
      out_src_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      if (bus_io.lane_rvalid && !res_take) err_q <= 1'b1;
      if (res_take) begin
        ret_cnt_q                     <= ret_cnt_nxt;
        out_x_q[W*ret_idx +: W]       <= res_x;
        out_p_q[2*W*ret_idx +: 2*W]   <= res_p;
      end
      unique case (state_q)
        StCollect: begin
          if (s1_fire) begin
            x1_q    <= bus_io.s1_x;
            p1_q    <= bus_io.s1_p;
            slot1_q <= 1'b1;
          end
          if (s2_fire) begin
            x2_q    <= bus_io.s2_x;
            p2_q    <= bus_io.s2_p;
            slot2_q <= 1'b1;
          end
          if (slot1_nxt && slot2_nxt) begin
            // Capture wins over timeout.
            state_q     <= StIssue;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            s1_ready_q  <= 1'b0;
            s2_ready_q  <= 1'b0;
          end else if (slot1_q ^ slot2_q) begin
            if (stale_q == StaleMax) begin
              state_q     <= StOutput;
              out_valid_q <= 1'b1;
              out_x_q     <= pt_x;
              out_p_q     <= pt_p;
              out_src_q   <= slot1_q ? 2'b01 : 2'b10;
              s1_ready_q  <= 1'b0;
              s2_ready_q  <= 1'b0;
            end else begin
              stale_q    <= stale_q + 1'b1;
              s1_ready_q <= !slot1_nxt;
              s2_ready_q <= !slot2_nxt;
            end
          end else begin
            // Nothing held yet, or the first slot fills on this edge.
            stale_q    <= '0;
            s1_ready_q <= !slot1_nxt;
            s2_ready_q <= !slot2_nxt;
          end
        end
        StIssue: begin
          if (issue_cnt_q != NCnt) begin
            lane_valid_q     <= 1'b1;
            lane_p1_q        <= p1_q[W*iss_idx +: W];
            lane_p2_q        <= p2_q[W*iss_idx +: W];
            lane_x1_q        <= x1_q[W*iss_idx +: W];
            lane_x2_q        <= x2_q[W*iss_idx +: W];
            zmask_q[iss_idx] <= iss_zero;
            issue_cnt_q      <= issue_cnt_q + 1'b1;
          end else begin
            lane_valid_q <= 1'b0;
            if (ret_cnt_nxt == NCnt) begin
              state_q     <= StOutput;
              out_valid_q <= 1'b1;
              out_src_q   <= 2'b11;
            end else begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (ret_cnt_nxt == NCnt) begin
            state_q     <= StOutput;
            out_valid_q <= 1'b1;
            out_src_q   <= 2'b11;
          end
        end
        StOutput: begin
          if (bus_io.out_ready) begin
            state_q     <= StCollect;
            out_valid_q <= 1'b0;
            slot1_q     <= 1'b0;
            slot2_q     <= 1'b0;
            stale_q     <= '0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            s1_ready_q  <= 1'b1;
            s2_ready_q  <= 1'b1;
          end
        end
        default: state_q <= StCollect;
      endcase
    end
  end

  assign bus_io.s1_ready   = s1_ready_q;
  assign bus_io.s2_ready   = s2_ready_q;
  assign bus_io.lane_valid = lane_valid_q;
  assign bus_io.lane_p1    = lane_p1_q;
  assign bus_io.lane_p2    = lane_p2_q;
  assign bus_io.lane_x1    = lane_x1_q;
  assign bus_io.lane_x2    = lane_x2_q;
  assign bus_io.out_valid  = out_valid_q;
  assign bus_io.out_x      = out_x_q;
  assign bus_io.out_p      = out_p_q;
  assign bus_io.out_src    = out_src_q;
  assign bus_io.err_unexp  = err_q;
endmodule

// File: tb/tb_fusion_sequencer.sv
// Directed bench for fusion_sequencer with a 3-cycle weighted-average lane model.
module tb_fusion_sequencer;
  localparam int unsigned N     = 6;
  localparam int unsigned W     = 16;
  localparam int unsigned STALE = 8;
  localparam int unsigned VW    = 2 * N * W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  fusion_sequencer_if #(.N(N), .W(W)) bus ();

  fusion_sequencer #(.N(N), .W(W), .STALE_CYC(STALE)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  // Lane model: xf = (P2*X1 + P1*X2) / (P1 + P2), pf = P1*P2, three pipeline stages.
  function automatic logic [W-1:0] lane_x(input logic [W-1:0] p1, p2, x1, x2);
    longint sp1 = longint'($signed(p1));
    longint sp2 = longint'($signed(p2));
    longint sx1 = longint'($signed(x1));
    longint sx2 = longint'($signed(x2));
    if (sp1 + sp2 == 0) return 16'hDEAD;
    return W'((sp2 * sx1 + sp1 * sx2) / (sp1 + sp2));
  endfunction

  function automatic logic [2*W-1:0] lane_p(input logic [W-1:0] p1, p2);
    longint sp1 = longint'($signed(p1));
    longint sp2 = longint'($signed(p2));
    return (2*W)'(sp1 * sp2);
  endfunction

  logic [2:0]     pv = '0;
  logic [W-1:0]   pxf [3];
  logic [2*W-1:0] ppf [3];

  always @(posedge clk) begin
    pv     <= {pv[1:0], bus.lane_valid};
    pxf[0] <= lane_x(bus.lane_p1, bus.lane_p2, bus.lane_x1, bus.lane_x2);
    ppf[0] <= lane_p(bus.lane_p1, bus.lane_p2);
    pxf[1] <= pxf[0];
    ppf[1] <= ppf[0];
    pxf[2] <= pxf[1];
    ppf[2] <= ppf[1];
  end

  assign bus.lane_rvalid = pv[2];
  assign bus.lane_xf     = pxf[2];
  assign bus.lane_pf     = ppf[2];

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_out(input string tag, input int budget);
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, " out_valid"}, VW'(bus.out_valid), VW'(1));
  endtask

  task automatic accept();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [N*W-1:0]   ex_x;
  logic [2*N*W-1:0] ex_p;
  logic [W-1:0]     lp2 [N];
  logic [W-1:0]     lx1 [N];

  initial begin
    bus.s1_valid  = 1'b0;
    bus.s2_valid  = 1'b0;
    bus.s1_x      = '0;
    bus.s1_p      = '0;
    bus.s2_x      = '0;
    bus.s2_p      = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst s1_ready",   VW'(bus.s1_ready),   '0);
    check("rst s2_ready",   VW'(bus.s2_ready),   '0);
    check("rst lane_valid", VW'(bus.lane_valid), '0);
    check("rst out_valid",  VW'(bus.out_valid),  '0);
    check("rst out_src",    VW'(bus.out_src),    '0);
    check("rst out_x",      VW'(bus.out_x),      '0);
    check("rst err",        VW'(bus.err_unexp),  '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-rst s1_ready", VW'(bus.s1_ready), VW'(1));
    check("post-rst s2_ready", VW'(bus.s2_ready), VW'(1));

    // 1: simultaneous capture, equal covariances
    bus.s1_x = {N{16'h0200}};
    bus.s1_p = {N{16'h0100}};
    bus.s2_x = {N{16'h0400}};
    bus.s2_p = {N{16'h0100}};
    bus.s1_valid = 1'b1;
    bus.s2_valid = 1'b1;
    @(negedge clk);
    bus.s1_valid = 1'b0;
    bus.s2_valid = 1'b0;
    check("t1 s1_ready busy", VW'(bus.s1_ready), '0);
    check("t1 s2_ready busy", VW'(bus.s2_ready), '0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check($sformatf("t1 lane_valid c%0d", k), VW'(bus.lane_valid), VW'(k <= 6));
      check($sformatf("t1 out_valid c%0d", k), VW'(bus.out_valid), VW'(k == 10));
    end
    check("t1 out_x",   VW'(bus.out_x), VW'({N{16'h0300}}));
    check("t1 out_p",   bus.out_p,      {N{32'h0001_0000}});
    check("t1 out_src", VW'(bus.out_src), VW'(2'b11));
    accept();
    check("t1 out_valid drop", VW'(bus.out_valid), '0);
    check("t1 s1_ready back",  VW'(bus.s1_ready),  VW'(1));

    // 4: zero covariance sum on element 2, distinct element 0, staggered capture
    bus.s1_p = {N{16'h0100}};
    bus.s2_p = {N{16'h0100}};
    bus.s1_x = {N{16'h0200}};
    bus.s2_x = {N{16'h0400}};
    bus.s1_p[0 +: W] = 16'h0100;
    bus.s2_p[0 +: W] = 16'h0300;
    bus.s1_x[0 +: W] = 16'h0100;
    bus.s2_x[0 +: W] = 16'h0500;
    bus.s1_p[2*W +: W] = 16'h0005;
    bus.s2_p[2*W +: W] = 16'hFFFB;
    bus.s1_x[2*W +: W] = 16'h0010;
    bus.s2_x[2*W +: W] = 16'h0020;
    bus.s1_valid = 1'b1;
    @(negedge clk);
    bus.s1_valid = 1'b0;
    @(negedge clk);
    bus.s2_valid = 1'b1;
    @(negedge clk);
    bus.s2_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      check($sformatf("t4 lane_valid i%0d", k), VW'(bus.lane_valid), VW'(1));
      lp2[k] = bus.lane_p2;
      lx1[k] = bus.lane_x1;
    end
    check("t4 issue0 p2", VW'(lp2[0]), VW'(16'h0300));
    check("t4 issue2 p2", VW'(lp2[2]), VW'(16'hFFFB));
    check("t4 issue2 x1", VW'(lx1[2]), VW'(16'h0010));
    check("t4 issue5 x1", VW'(lx1[5]), VW'(16'h0200));
    wait_out("t4", 20);
    ex_x = {N{16'h0300}};
    ex_x[0 +: W]   = 16'h0200;
    ex_x[2*W +: W] = 16'h0018;
    ex_p = {N{32'h0001_0000}};
    ex_p[0 +: 2*W]     = 32'h0003_0000;
    ex_p[2*2*W +: 2*W] = 32'h0000_0000;
    check("t4 out_x",   VW'(bus.out_x), VW'(ex_x));
    check("t4 out_p",   bus.out_p,      ex_p);
    check("t4 out_src", VW'(bus.out_src), VW'(2'b11));
    accept();

    // 2: sensor 1 only -> pass-through after STALE cycles
    bus.s1_x = {16'h1005, 16'h1004, 16'h1003, 16'h1002, 16'h1001, 16'h1000};
    bus.s1_p = {16'h000C, 16'h000B, 16'h000A, 16'h0009, 16'h0008, 16'h8001};
    bus.s1_valid = 1'b1;
    @(negedge clk);
    bus.s1_valid = 1'b0;
    check("t2 s1_ready", VW'(bus.s1_ready), '0);
    check("t2 s2_ready", VW'(bus.s2_ready), VW'(1));
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("t2 out_valid c%0d", k), VW'(bus.out_valid), VW'(k == 8));
    end
    ex_x = {16'h1005, 16'h1004, 16'h1003, 16'h1002, 16'h1001, 16'h1000};
    ex_p = {32'h0000_000C, 32'h0000_000B, 32'h0000_000A, 32'h0000_0009, 32'h0000_0008,
            32'hFFFF_8001};
    check("t2 out_x",      VW'(bus.out_x), VW'(ex_x));
    check("t2 out_p",      bus.out_p,      ex_p);
    check("t2 out_src",    VW'(bus.out_src), VW'(2'b01));
    check("t2 lane_valid", VW'(bus.lane_valid), '0);

    // 5: consumer stalls for 10 cycles, s2 offers and withdraws meanwhile
    bus.s2_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("t5 hold valid c%0d", k), VW'(bus.out_valid), VW'(1));
      check($sformatf("t5 hold x c%0d", k),     VW'(bus.out_x), VW'(ex_x));
      check($sformatf("t5 hold p c%0d", k),     bus.out_p, ex_p);
      check($sformatf("t5 hold rdy c%0d", k),   VW'({bus.s1_ready, bus.s2_ready}), '0);
    end
    bus.s2_valid = 1'b0;
    check("t5 src held", VW'(bus.out_src), VW'(2'b01));
    accept();
    check("t5 s1_ready after", VW'(bus.s1_ready),  VW'(1));
    check("t5 s2_ready after", VW'(bus.s2_ready),  VW'(1));
    check("t5 out_valid drop", VW'(bus.out_valid), '0);

    // sensor 2 only -> pass-through tagged 10
    bus.s2_x = {N{16'hABCD}};
    bus.s2_p = {N{16'hFFF0}};
    bus.s2_valid = 1'b1;
    @(negedge clk);
    bus.s2_valid = 1'b0;
    wait_out("s2only", 12);
    check("s2only out_src", VW'(bus.out_src), VW'(2'b10));
    check("s2only out_x",   VW'(bus.out_x), VW'({N{16'hABCD}}));
    check("s2only out_p",   bus.out_p, {N{32'hFFFF_FFF0}});
    accept();

    // 3: sensor 2 arrives on the timeout edge -> fused, not pass-through
    bus.s1_x = {N{16'h0200}};
    bus.s1_p = {N{16'h0100}};
    bus.s2_x = {N{16'h0400}};
    bus.s2_p = {N{16'h0100}};
    bus.s1_valid = 1'b1;
    @(negedge clk);
    bus.s1_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("t3 s2_ready at edge", VW'(bus.s2_ready), VW'(1));
    bus.s2_valid = 1'b1;
    @(negedge clk);
    bus.s2_valid = 1'b0;
    check("t3 no pass-through", VW'(bus.out_valid), '0);
    check("t3 s2 captured",     VW'(bus.s2_ready),  '0);
    @(negedge clk);
    check("t3 issue started",   VW'(bus.lane_valid), VW'(1));
    wait_out("t3", 20);
    check("t3 out_src", VW'(bus.out_src), VW'(2'b11));
    check("t3 out_x",   VW'(bus.out_x), VW'({N{16'h0300}}));
    accept();
    check("pre-t6 err", VW'(bus.err_unexp), '0);

    // 6: reset during DRAIN, late lane result afterwards
    bus.s1_valid = 1'b1;
    bus.s2_valid = 1'b1;
    @(negedge clk);
    bus.s1_valid = 1'b0;
    bus.s2_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("t6 in drain", VW'({bus.lane_valid, bus.out_valid}), '0);
    #1 rst_n = 1'b0;
    #1;
    check("t6 rst out_valid", VW'(bus.out_valid), '0);
    check("t6 rst out_x",     VW'(bus.out_x), '0);
    check("t6 rst ready",     VW'({bus.s1_ready, bus.s2_ready}), '0);
    check("t6 rst err",       VW'(bus.err_unexp), '0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("t6 err set", VW'(bus.err_unexp), VW'(1));
    repeat (4) @(negedge clk);
    check("t6 err sticky",    VW'(bus.err_unexp), VW'(1));
    check("t6 out_valid low", VW'(bus.out_valid), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
